// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the chip-enable/write-enable memory bus.
// The controller and the memory responder both import this package.
package mem_bus_pkg;

  localparam int NUM_BANKS = 4;
  localparam logic [NUM_BANKS-1:0] IDLE_STB = 4'b1111;

  typedef enum logic [1:0] {
    PWR_OFF  = 2'd0,
    PWR_UP   = 2'd1,
    PWR_ON   = 2'd2,
    PWR_DOWN = 2'd3
  } pwr_state_t;

  // Index of the lowest zero bit of an active-low strobe vector.
  function automatic logic [1:0] bank_idx(input logic [NUM_BANKS-1:0] ceb_n);
    bank_idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (!ceb_n[i]) bank_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Memory bus bundle: strobes, address/data, power handshake and error flags.
// The controller drives through master; the memory responder uses slave.
interface mem_bus_if
  import mem_bus_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) ();

  logic [NUM_BANKS-1:0] ceb;
  logic [NUM_BANKS-1:0] web;
  logic [AW-1:0]        addr;
  logic [DW-1:0]        din;
  logic [DW-1:0]        dout;
  logic                 dout_vld;
  logic                 pwr_req;
  logic                 ret;
  logic                 pwr_ack;
  logic                 err_clr;
  logic                 err_multi;
  logic                 err_off;
  logic                 rd_inv;

  modport master (
    output ceb, web, addr, din, pwr_req, ret, err_clr,
    input  dout, dout_vld, pwr_ack, err_multi, err_off, rd_inv
  );

  modport slave (
    input  ceb, web, addr, din, pwr_req, ret, err_clr,
    output dout, dout_vld, pwr_ack, err_multi, err_off, rd_inv
  );

endinterface

// File: rtl/mem_pwr_fsm.sv
// Power sequencer for the memory banks: OFF -> UP -> ON -> DOWN -> OFF.
// Transitions always run to completion; clr_valid pulses on the DOWN->OFF edge without retention.
module mem_pwr_fsm
  import mem_bus_pkg::*;
#(
  parameter int PWR_LAT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pwr_req,
  input  logic       ret,
  output pwr_state_t state,
  output logic       pwr_ack,
  output logic       clr_valid
);

  localparam logic [3:0] LAST = 4'(PWR_LAT - 1);

  pwr_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= PWR_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_valid = 1'b0;
    case (state_q)
      PWR_OFF: begin
        if (pwr_req) begin
          state_d = PWR_UP;
          cnt_d   = '0;
        end
      end
      PWR_UP: begin
        if (cnt_q == LAST) begin
          state_d = PWR_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PWR_ON: begin
        if (!pwr_req) begin
          state_d = PWR_DOWN;
          cnt_d   = '0;
        end
      end
      PWR_DOWN: begin
        if (cnt_q == LAST) begin
          state_d   = PWR_OFF;
          cnt_d     = '0;
          clr_valid = !ret;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = PWR_OFF;
    endcase
  end

  assign state   = state_q;
  assign pwr_ack = (state_q == PWR_ON);

endmodule

// File: rtl/mem_bank_resp.sv
// Four-bank SRAM responder on the ceb/web bus with per-word valid tracking,
// one-cycle read latency, sticky protocol error flags and a power sequencer.
module mem_bank_resp
  import mem_bus_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int PWR_LAT = 4
) (
  input logic       clk,
  input logic       rstn,
  mem_bus_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    mem   [NUM_BANKS][DEPTH];
  logic [DEPTH-1:0] valid [NUM_BANKS];

  pwr_state_t state;
  logic       clr_valid;
  logic       pwr_ack;

  logic [2:0] sel;
  logic [1:0] bank;
  logic       idle, multi_err, off_err, wr, rd, hit_valid;

  logic [DW-1:0] dout_q;
  logic          dout_vld_q, rd_inv_q, err_multi_q, err_off_q;

  mem_pwr_fsm #(.PWR_LAT(PWR_LAT)) u_pwr (
    .clk       (clk),
    .rstn      (rstn),
    .pwr_req   (bus.pwr_req),
    .ret       (bus.ret),
    .state     (state),
    .pwr_ack   (pwr_ack),
    .clr_valid (clr_valid)
  );

  // Exactly one low ceb bit selects a bank; the state gates whether it is served.
  always_comb begin
    sel       = 3'($countones(~bus.ceb));
    bank      = bank_idx(bus.ceb);
    idle      = (bus.ceb == IDLE_STB);
    multi_err = (sel > 3'd1);
    off_err   = !idle && !multi_err && (state != PWR_ON);
    wr        = !idle && !multi_err && (state == PWR_ON) && !bus.web[bank];
    rd        = !idle && !multi_err && (state == PWR_ON) &&  bus.web[bank];
    hit_valid = valid[bank][bus.addr];
  end

  // NOTE: the data array is deliberately not reset; the valid bitmap alone marks what may be returned.
  always_ff @(posedge clk) begin
    if (wr) mem[bank][bus.addr] <= bus.din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < NUM_BANKS; b++) valid[b] <= '0;
    end else if (clr_valid) begin
      for (int b = 0; b < NUM_BANKS; b++) valid[b] <= '0;
    end else if (wr) begin
      valid[bank][bus.addr] <= 1'b1;
    end
  end

  // Set beats clear on the sticky flags when both happen in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      rd_inv_q    <= 1'b0;
      err_multi_q <= 1'b0;
      err_off_q   <= 1'b0;
    end else begin
      dout_vld_q  <= rd;
      rd_inv_q    <= rd && !hit_valid;
      if (rd) dout_q <= hit_valid ? mem[bank][bus.addr] : '0;
      err_multi_q <= (err_multi_q && !bus.err_clr) || multi_err;
      err_off_q   <= (err_off_q   && !bus.err_clr) || off_err;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.rd_inv    = rd_inv_q;
  assign bus.err_multi = err_multi_q;
  assign bus.err_off   = err_off_q;
  assign bus.pwr_ack   = pwr_ack;

endmodule

// File: tb/tb_mem_bank_resp.sv
// Self-checking bench for mem_bank_resp: directed vector table, hand-written
// power/reset sequences and a randomized run against a behavioural model.
module tb_mem_bank_resp;
  import mem_bus_pkg::*;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_bus_if #(.DW(8), .AW(8)) bus ();

  mem_bank_resp #(.DW(8), .AW(8), .PWR_LAT(L)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: memory contents, valid words, power mode with countdown.
  logic [7:0] m_mem [4][256];
  bit         m_val [4][256];
  bit         m_on, m_target;
  int         m_busy;
  logic [7:0] m_dout;
  bit         m_vld, m_inv, m_multi, m_off;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_target = 0; m_busy = 0;
    m_dout = 8'h00; m_vld = 0; m_inv = 0; m_multi = 0; m_off = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) m_val[b][a] = 0;
  endtask

  // Applies the rules for one rising edge using the inputs present before it.
  task automatic model_edge();
    int  zeros, b;
    bit  ready;
    if (!rstn) begin
      model_reset();
      return;
    end
    zeros = $countones(~bus.ceb);
    ready = (m_busy == 0) && m_on;
    m_multi = (m_multi && !bus.err_clr) || (zeros > 1);
    m_off   = (m_off && !bus.err_clr) || (zeros == 1 && !ready);
    m_vld = 0; m_inv = 0;
    if (zeros == 1 && ready) begin
      b = 0;
      for (int i = 0; i < 4; i++) if (!bus.ceb[i]) b = i;
      if (!bus.web[b]) begin
        m_mem[b][bus.addr] = bus.din;
        m_val[b][bus.addr] = 1;
      end else begin
        m_vld  = 1;
        m_inv  = !m_val[b][bus.addr];
        m_dout = m_val[b][bus.addr] ? m_mem[b][bus.addr] : 8'h00;
      end
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_on = m_target;
        if (!m_target && !bus.ret)
          for (int bb = 0; bb < 4; bb++)
            for (int a = 0; a < 256; a++) m_val[bb][a] = 0;
      end
    end else if (m_on != bus.pwr_req) begin
      m_busy   = L;
      m_target = bus.pwr_req;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("dout",      bus.dout,      m_dout);
    check("dout_vld",  bus.dout_vld,  m_vld);
    check("rd_inv",    bus.rd_inv,    m_inv);
    check("err_multi", bus.err_multi, m_multi);
    check("err_off",   bus.err_off,   m_off);
    check("pwr_ack",   bus.pwr_ack,   (m_busy == 0) && m_on);
  endtask

  task automatic drive(input logic [3:0] ceb, input logic [3:0] web,
                       input logic [7:0] addr, input logic [7:0] din);
    bus.ceb = ceb; bus.web = web; bus.addr = addr; bus.din = din;
  endtask

  task automatic idle();
    drive(IDLE_STB, IDLE_STB, 8'h00, 8'h00);
  endtask

  task automatic expect_rd(input string name, input logic [7:0] d, input logic v, input logic inv);
    check({name, "_dout"},   bus.dout,     d);
    check({name, "_vld"},    bus.dout_vld, v);
    check({name, "_rd_inv"}, bus.rd_inv,   inv);
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.pwr_ack && n <= budget);
  endtask

  // Asserts reset a few ns into the cycle and checks outputs before any edge.
  task automatic async_reset(input string name);
    #3 rstn = 1'b0;
    #1;
    model_reset();
    check({name, "_ack"},    bus.pwr_ack,   1'b0);
    check({name, "_vld"},    bus.dout_vld,  1'b0);
    check({name, "_dout"},   bus.dout,      8'h00);
    check({name, "_inv"},    bus.rd_inv,    1'b0);
    check({name, "_multi"},  bus.err_multi, 1'b0);
    check({name, "_off"},    bus.err_off,   1'b0);
  endtask

  typedef struct {
    logic [3:0] ceb, web;
    logic [7:0] addr, din;
    logic       err_clr;
    logic [7:0] e_dout;
    logic       e_vld, e_inv, e_multi, e_off, e_ack;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int n, r;
    tbl[0]  = '{4'b1011, 4'b1011, 8'h05, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{4'b1011, 4'b1111, 8'h05, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{4'b1110, 4'b1111, 8'h10, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{4'b1111, 4'b0000, 8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{4'b1100, 4'b1111, 8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{4'b1111, 4'b1111, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{4'b1111, 4'b1111, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{4'b1101, 4'b1101, 8'h05, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{4'b1101, 4'b1111, 8'h05, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{4'b1011, 4'b1111, 8'h05, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{4'b0000, 4'b1111, 8'h05, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{4'b1111, 4'b1111, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{4'b0111, 4'b0000, 8'hFF, 8'h5A, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{4'b1110, 4'b0001, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{4'b0111, 4'b1000, 8'hFF, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rstn = 1'b0;
    idle();
    bus.pwr_req = 1'b1; bus.ret = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    #22;
    check("rst_dout",  bus.dout,      8'h00);
    check("rst_vld",   bus.dout_vld,  1'b0);
    check("rst_inv",   bus.rd_inv,    1'b0);
    check("rst_multi", bus.err_multi, 1'b0);
    check("rst_off",   bus.err_off,   1'b0);
    check("rst_ack",   bus.pwr_ack,   1'b0);

    // Power-up: first edge is OFF->UP, ack rises L edges later.
    rstn = 1'b1;
    step();
    check("off_up_ack", bus.pwr_ack, 1'b0);
    wait_ack(20, n);
    check("pwr_up_latency", n, L);

    foreach (tbl[i]) begin
      drive(tbl[i].ceb, tbl[i].web, tbl[i].addr, tbl[i].din);
      bus.err_clr = tbl[i].err_clr;
      step();
      check($sformatf("vec%0d_dout", i),  bus.dout,      tbl[i].e_dout);
      check($sformatf("vec%0d_vld", i),   bus.dout_vld,  tbl[i].e_vld);
      check($sformatf("vec%0d_inv", i),   bus.rd_inv,    tbl[i].e_inv);
      check($sformatf("vec%0d_multi", i), bus.err_multi, tbl[i].e_multi);
      check($sformatf("vec%0d_off", i),   bus.err_off,   tbl[i].e_off);
      check($sformatf("vec%0d_ack", i),   bus.pwr_ack,   tbl[i].e_ack);
    end
    idle(); bus.err_clr = 1'b0;

    // Power down without retention; the read in the ON->DOWN cycle is still served.
    bus.pwr_req = 1'b0; bus.ret = 1'b0;
    drive(4'b1011, 4'b1111, 8'h05, 8'h00);
    step();
    expect_rd("on_down_rd", 8'hA5, 1'b1, 1'b0);
    check("on_down_ack", bus.pwr_ack, 1'b0);
    drive(4'b1110, 4'b1110, 8'h20, 8'h77);
    step();
    check("down_access_off", bus.err_off, 1'b1);
    idle(); bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("err_off_clr", bus.err_off, 1'b0);
    repeat (L) step();
    bus.pwr_req = 1'b1;
    wait_ack(20, n);
    check("ret0_up_latency", n, L + 1);
    drive(4'b1011, 4'b1111, 8'h05, 8'h00);
    step();
    expect_rd("ret0_rd", 8'h00, 1'b1, 1'b1);

    // Power down with retention; the write attempted in DOWN must not land.
    drive(4'b1011, 4'b1011, 8'h05, 8'hA5);
    step();
    idle(); bus.pwr_req = 1'b0; bus.ret = 1'b1;
    step();
    drive(4'b1110, 4'b1110, 8'h20, 8'h77);
    step();
    check("ret1_down_off", bus.err_off, 1'b1);
    idle();
    repeat (L) step();
    bus.pwr_req = 1'b1;
    wait_ack(20, n);
    check("ret1_up_latency", n, L + 1);
    drive(4'b1011, 4'b1111, 8'h05, 8'h00);
    step();
    expect_rd("ret1_rd", 8'hA5, 1'b1, 1'b0);
    drive(4'b1110, 4'b1111, 8'h20, 8'h00);
    step();
    expect_rd("blocked_wr_rd", 8'h00, 1'b1, 1'b1);
    check("err_off_sticky", bus.err_off, 1'b1);
    idle(); bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;

    // pwr_req reverses mid-DOWN: DOWN completes, OFF, UP, then ON.
    bus.pwr_req = 1'b0;
    step();
    check("rev_down_ack", bus.pwr_ack, 1'b0);
    step();
    bus.pwr_req = 1'b1;
    wait_ack(30, n);
    check("rev_edges_to_on", n + 1, 2 * L + 1);

    // Reset with a read result pending, during a DOWN transition.
    drive(4'b0000, 4'b1111, 8'h00, 8'h00);
    step();
    bus.pwr_req = 1'b0;
    drive(4'b1011, 4'b1111, 8'h05, 8'h00);
    step();
    check("inflight_vld", bus.dout_vld, 1'b1);
    idle();
    async_reset("rst_down");
    step();
    rstn = 1'b1; bus.pwr_req = 1'b1;
    step();
    step();
    drive(4'b1110, 4'b1111, 8'h00, 8'h00);
    step();
    check("up_access_off", bus.err_off, 1'b1);
    idle();
    async_reset("rst_up");
    rstn = 1'b1;
    wait_ack(20, n);
    check("post_rst_up_latency", n, L + 1);
    drive(4'b1011, 4'b1111, 8'h05, 8'h00);
    step();
    expect_rd("post_rst_rd", 8'h00, 1'b1, 1'b1);

    // Randomized traffic against the model.
    bus.pwr_req = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      bus.ceb = IDLE_STB;
      else if (r < 85) bus.ceb = ~(4'b0001 << $urandom_range(0, 3));
      else             bus.ceb = 4'($urandom);
      bus.web     = 4'($urandom);
      bus.addr    = 8'($urandom_range(0, 7));
      bus.din     = 8'($urandom);
      bus.err_clr = ($urandom_range(0, 19) == 0);
      bus.ret     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) bus.pwr_req = ~bus.pwr_req;
      rstn = ($urandom_range(0, 299) != 0);
      step();
    end
    rstn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
